// File: rtl/ekf_spi_frame_bridge.sv
// SPI byte stream <-> EKF control FSM bridge: deframes [cmd][len][words] into beats, serializes response words MSB-first.
// Latency: beat valid 1 cycle after its last byte; first tx byte valid 1 cycle after response capture.
// Backpressure: rx cannot stall (beat overwritten -> rx_overrun); tx waits on tx_ready. Optional EKF_BRIDGE_TX_CSUM_EN appends an XOR byte.
module ekf_spi_frame_bridge #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            rx_byte,
    input  logic                  rx_valid,
    input  logic                  spi_frame_end,
    output logic [7:0]            cmd,
    output logic [7:0]            payload_length,
    output logic [DATA_WIDTH-1:0] payload_data,
    output logic                  payload_valid,
    input  logic                  payload_ready,
    input  logic [DATA_WIDTH-1:0] response_data,
    input  logic                  response_valid,
    output logic                  response_ready,
    output logic [7:0]            tx_byte,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  rx_overrun,
    output logic                  frame_error
);
    localparam int BYTES_PER_WORD = DATA_WIDTH / 8;
`ifdef EKF_BRIDGE_TX_CSUM_EN
    localparam int TX_BYTES = BYTES_PER_WORD + 1;
`else
    localparam int TX_BYTES = BYTES_PER_WORD;
`endif
    localparam int BCW = $clog2(BYTES_PER_WORD + 1);
    localparam int TCW = $clog2(TX_BYTES + 1);

    typedef enum logic [1:0] {R_CMD, R_LEN, R_DATA} rx_state_t;
    typedef enum logic {T_IDLE, T_SEND} tx_state_t;

    rx_state_t             rx_state;
    logic [BCW-1:0]        byte_cnt;
    logic [7:0]            words_left;
    logic [DATA_WIDTH-1:0] asm_q;
    logic [DATA_WIDTH-1:0] word_val;
    logic                  last_byte;
    logic                  hdr_load;
    logic                  word_load;
    logic                  frame_done;
    logic                  abort_frame;
    logic                  load_req;
    logic [DATA_WIDTH-1:0] load_val;
    logic                  accept;

    assign word_val    = (asm_q << 8) | DATA_WIDTH'(rx_byte);
    assign last_byte   = (byte_cnt == BCW'(BYTES_PER_WORD - 1));
    assign hdr_load    = (rx_state == R_LEN) && rx_valid;
    assign word_load   = (rx_state == R_DATA) && rx_valid && last_byte;
    // A byte that completes the frame in the same cycle as chip-select release is not a truncation.
    assign frame_done  = (hdr_load && rx_byte == 8'd0) || (word_load && words_left == 8'd1);
    assign abort_frame = spi_frame_end && (rx_state != R_CMD) && !frame_done;
    assign load_req    = hdr_load || word_load;
    assign load_val    = hdr_load ? '0 : word_val;
    assign accept      = payload_valid && payload_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state       <= R_CMD;
            byte_cnt       <= '0;
            words_left     <= '0;
            asm_q          <= '0;
            cmd            <= '0;
            payload_length <= '0;
            payload_data   <= '0;
            payload_valid  <= 1'b0;
            rx_overrun     <= 1'b0;
            frame_error    <= 1'b0;
        end else begin
            rx_overrun  <= 1'b0;
            frame_error <= 1'b0;
            case (rx_state)
                R_CMD: begin
                    if (rx_valid) begin
                        cmd      <= rx_byte;
                        rx_state <= R_LEN;
                    end
                end
                R_LEN: begin
                    if (rx_valid) begin
                        payload_length <= rx_byte;
                        words_left     <= rx_byte;
                        byte_cnt       <= '0;
                        rx_state       <= (rx_byte == 8'd0) ? R_CMD : R_DATA;
                    end
                end
                R_DATA: begin
                    if (rx_valid) begin
                        asm_q <= word_val;
                        if (last_byte) begin
                            byte_cnt   <= '0;
                            words_left <= words_left - 8'd1;
                            if (words_left == 8'd1) rx_state <= R_CMD;
                        end else begin
                            byte_cnt <= byte_cnt + BCW'(1);
                        end
                    end
                end
                default: rx_state <= R_CMD;
            endcase

            if (abort_frame) begin
                rx_state    <= R_CMD;
                byte_cnt    <= '0;
                frame_error <= 1'b1;
            end

            // Single-entry beat register: a new beat while the old one is still unaccepted is dropped.
            if (load_req) begin
                if (!payload_valid || accept) begin
                    payload_data  <= load_val;
                    payload_valid <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (accept) begin
                payload_valid <= 1'b0;
            end
        end
    end

`ifdef EKF_BRIDGE_TX_CSUM_EN
    function automatic logic [7:0] xor_bytes(input logic [DATA_WIDTH-1:0] w);
        logic [7:0] x;
        x = '0;
        for (int i = 0; i < BYTES_PER_WORD; i++) x = x ^ w[i*8 +: 8];
        return x;
    endfunction

    logic [7:0] csum_q;
`endif

    tx_state_t             tx_state;
    logic [DATA_WIDTH-1:0] tx_sh;
    logic [TCW-1:0]        tx_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state       <= T_IDLE;
            tx_sh          <= '0;
            tx_idx         <= '0;
            tx_byte        <= '0;
            tx_valid       <= 1'b0;
            response_ready <= 1'b1;
`ifdef EKF_BRIDGE_TX_CSUM_EN
            csum_q         <= '0;
`endif
        end else begin
            case (tx_state)
                T_IDLE: begin
                    if (response_valid) begin
                        tx_byte        <= response_data[DATA_WIDTH-1 -: 8];
                        tx_sh          <= response_data << 8;
                        tx_idx         <= '0;
                        tx_valid       <= 1'b1;
                        response_ready <= 1'b0;
                        tx_state       <= T_SEND;
`ifdef EKF_BRIDGE_TX_CSUM_EN
                        csum_q         <= xor_bytes(response_data);
`endif
                    end
                end
                T_SEND: begin
                    if (tx_ready) begin
                        if (tx_idx == TCW'(TX_BYTES - 1)) begin
                            tx_valid       <= 1'b0;
                            response_ready <= 1'b1;
                            tx_state       <= T_IDLE;
                        end else begin
                            tx_idx  <= tx_idx + TCW'(1);
                            tx_sh   <= tx_sh << 8;
`ifdef EKF_BRIDGE_TX_CSUM_EN
                            tx_byte <= (tx_idx == TCW'(BYTES_PER_WORD - 1)) ? csum_q
                                                                           : tx_sh[DATA_WIDTH-1 -: 8];
`else
                            tx_byte <= tx_sh[DATA_WIDTH-1 -: 8];
`endif
                        end
                    end
                end
                default: tx_state <= T_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ekf_spi_frame_bridge.sv
// Scoreboard bench for ekf_spi_frame_bridge: directed frames and responses, monitor pops expected beats/bytes.
module tb_ekf_spi_frame_bridge;
`ifdef EKF_BRIDGE_TX_CSUM_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        spi_frame_end;
    logic [7:0]  cmd;
    logic [7:0]  payload_length;
    logic [31:0] payload_data;
    logic        payload_valid;
    logic        payload_ready;
    logic [31:0] response_data;
    logic        response_valid;
    logic        response_ready;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready;
    logic        rx_overrun;
    logic        frame_error;

    always #5 clk = ~clk;

    ekf_spi_frame_bridge #(.DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_byte(rx_byte), .rx_valid(rx_valid), .spi_frame_end(spi_frame_end),
        .cmd(cmd), .payload_length(payload_length), .payload_data(payload_data),
        .payload_valid(payload_valid), .payload_ready(payload_ready),
        .response_data(response_data), .response_valid(response_valid),
        .response_ready(response_ready),
        .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_overrun(rx_overrun), .frame_error(frame_error)
    );

    typedef struct {
        logic [7:0]  c;
        logic [7:0]  l;
        logic [31:0] d;
    } beat_t;

    beat_t      beat_q[$];
    logic [7:0] tx_q[$];
    beat_t      mon_beat;
    logic [7:0] mon_byte;
    int         ncmp = 0;
    int         nerr = 0;
    int         ovr_cnt = 0;
    int         fe_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_beat(input logic [7:0] c, input logic [7:0] l, input logic [31:0] d);
        beat_t b;
        b.c = c; b.l = l; b.d = d;
        beat_q.push_back(b);
    endtask

    task automatic rx(input logic [7:0] b, input logic fe);
        rx_byte = b; rx_valid = 1'b1; spi_frame_end = fe;
        @(posedge clk); #1;
        rx_valid = 1'b0; spi_frame_end = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((beat_q.size() != 0 || tx_q.size() != 0) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk({name, " pending beats"}, 32'(beat_q.size()), 32'd0);
        chk({name, " pending tx bytes"}, 32'(tx_q.size()), 32'd0);
    endtask

    // Monitor: every accepted beat / byte is checked against the head of its queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_overrun)  ovr_cnt++;
            if (frame_error) fe_cnt++;
            if (payload_valid && payload_ready) begin
                if (beat_q.size() == 0) begin
                    ncmp++; nerr++;
                    $display("FAIL unexpected beat: got cmd %h len %h data %h, none expected",
                             cmd, payload_length, payload_data);
                end else begin
                    mon_beat = beat_q.pop_front();
                    chk("beat cmd",  32'(cmd),            32'(mon_beat.c));
                    chk("beat len",  32'(payload_length), 32'(mon_beat.l));
                    chk("beat data", payload_data,        mon_beat.d);
                end
            end
            if (tx_valid && tx_ready) begin
                if (tx_q.size() == 0) begin
                    ncmp++; nerr++;
                    $display("FAIL unexpected tx byte: got %h, none expected", tx_byte);
                end else begin
                    mon_byte = tx_q.pop_front();
                    chk("tx byte", 32'(tx_byte), 32'(mon_byte));
                end
            end
        end
    end

    initial begin
        bit pat [6];
        int acc;
        int n;
        int base_ovr;
        int base_fe;

        rst_n = 1'b0; rx_byte = '0; rx_valid = 1'b0; spi_frame_end = 1'b0;
        payload_ready = 1'b1; response_data = '0; response_valid = 1'b0; tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset cmd",            32'(cmd),            32'd0);
        chk("reset payload_length", 32'(payload_length), 32'd0);
        chk("reset payload_data",   payload_data,        32'd0);
        chk("reset valids",         32'({payload_valid, tx_valid, rx_overrun, frame_error}), 32'd0);
        chk("reset tx_byte",        32'(tx_byte),        32'd0);
        chk("reset response_ready", 32'(response_ready), 32'd1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Two-word frame, always ready
        exp_beat(8'h01, 8'h02, 32'h0);
        exp_beat(8'h01, 8'h02, 32'hDEADBEEF);
        exp_beat(8'h01, 8'h02, 32'h00000005);
        rx(8'h01, 1'b0); rx(8'h02, 1'b0);
        rx(8'hDE, 1'b0); rx(8'hAD, 1'b0); rx(8'hBE, 1'b0); rx(8'hEF, 1'b0);
        rx(8'h00, 1'b0); rx(8'h00, 1'b0); rx(8'h00, 1'b0); rx(8'h05, 1'b0);
        drain("two-word frame");

        // Zero-length frame
        exp_beat(8'h10, 8'h00, 32'h0);
        rx(8'h10, 1'b0); rx(8'h00, 1'b0);
        drain("zero-length frame");

        // Stalled consumer: header held, both words dropped
        base_ovr = ovr_cnt;
        payload_ready = 1'b0;
        exp_beat(8'h30, 8'h02, 32'h0);
        rx(8'h30, 1'b0); rx(8'h02, 1'b0);
        for (int i = 1; i <= 8; i++) rx(8'(i), 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("held beat valid", 32'(payload_valid), 32'd1);
        chk("held beat data",  payload_data,       32'd0);
        payload_ready = 1'b1;
        drain("stalled frame");
        chk("overrun pulses", 32'(ovr_cnt - base_ovr), 32'd2);

        // Truncated frame, then recovery; chip-select release in idle and on the final byte
        base_fe = fe_cnt;
        exp_beat(8'h02, 8'h03, 32'h0);
        rx(8'h02, 1'b0); rx(8'h03, 1'b0); rx(8'h11, 1'b0); rx(8'h22, 1'b0);
        spi_frame_end = 1'b1;
        @(posedge clk); #1;
        spi_frame_end = 1'b0;
        exp_beat(8'h20, 8'h00, 32'h0);
        rx(8'h20, 1'b0); rx(8'h00, 1'b0);
        drain("truncated frame");
        spi_frame_end = 1'b1;
        @(posedge clk); #1;
        spi_frame_end = 1'b0;
        exp_beat(8'h40, 8'h01, 32'h0);
        exp_beat(8'h40, 8'h01, 32'h0A0B0C0D);
        rx(8'h40, 1'b0); rx(8'h01, 1'b0); rx(8'h0A, 1'b0); rx(8'h0B, 1'b0); rx(8'h0C, 1'b0);
        rx(8'h0D, 1'b1);
        drain("end on last byte");
        chk("frame_error pulses", 32'(fe_cnt - base_fe), 32'd1);

        // Response with stuttering tx_ready
        tx_q.push_back(8'h12); tx_q.push_back(8'h34); tx_q.push_back(8'h56); tx_q.push_back(8'h78);
`ifdef EKF_BRIDGE_TX_CSUM_EN
        tx_q.push_back(8'h08);
`endif
        response_data = 32'h12345678; response_valid = 1'b1;
        @(posedge clk); #1;
        response_valid = 1'b0;
        chk("tx first valid", 32'(tx_valid), 32'd1);
        chk("tx first byte",  32'(tx_byte),  32'h12);
        chk("rr after capture", 32'(response_ready), 32'd0);
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        acc = 0;
        for (int i = 0; i < 8 && acc < NB; i++) begin
            tx_ready = (i < 6) ? pat[i] : 1'b1;
            @(posedge clk); #1;
            if (tx_ready) acc++;
            chk("rr during send", 32'(response_ready), 32'(acc == NB));
        end
        tx_ready = 1'b0;
        chk("tx idle after word", 32'(tx_valid), 32'd0);
        drain("stutter response");

        // Response with tx_ready held high: one byte per cycle
        tx_q.push_back(8'hCA); tx_q.push_back(8'hFE); tx_q.push_back(8'hF0); tx_q.push_back(8'h0D);
`ifdef EKF_BRIDGE_TX_CSUM_EN
        tx_q.push_back(8'hC9);
`endif
        tx_ready = 1'b1;
        response_data = 32'hCAFEF00D; response_valid = 1'b1;
        @(posedge clk); #1;
        response_valid = 1'b0;
        n = 0;
        while (!response_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("burst send cycles", 32'(n), 32'(NB));
        tx_ready = 1'b0;
        drain("burst response");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/ekf_spi_frame_bridge.md
Name: ekf_spi_frame_bridge

Overview:
- Sits between the SPI slave byte shifter and the EKF control FSM.
- Receive side: deframes the incoming SPI byte stream into command/payload beats that drive the control FSM's `cmd` / `payload_length` / `payload_data` / `payload_valid` / `payload_ready` interface.
- Transmit side: accepts response words from the control FSM (`response_data` / `response_valid` / `response_ready`) and serializes them MSB-first into SPI transmit bytes.

Parameters:
- DATA_WIDTH, 32, payload/response word width; must be a multiple of 8.
- BYTES_PER_WORD, DATA_WIDTH/8, derived localparam; bytes per word.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rx_byte  in  8  received SPI byte.
- rx_valid  in  1  one-cycle strobe, rx_byte valid; cannot be stalled.
- spi_frame_end  in  1  one-cycle pulse when chip-select deasserts.
- cmd  out  8  command byte of current frame.
- payload_length  out  8  word count of current frame.
- payload_data  out  DATA_WIDTH  payload word.
- payload_valid  out  1  beat valid.
- payload_ready  in  1  beat accepted when valid&&ready.
- response_data  in  DATA_WIDTH  response word.
- response_valid  in  1  response word valid.
- response_ready  out  1  bridge can capture a response word.
- tx_byte  out  8  byte to SPI shifter.
- tx_valid  out  1  tx_byte valid.
- tx_ready  in  1  shifter accepts tx_byte.
- rx_overrun  out  1  one-cycle pulse: word dropped.
- frame_error  out  1  one-cycle pulse: frame truncated by spi_frame_end.

Behaviour:
- Reset values:
  - cmd, payload_length, payload_data, tx_byte = 0.
  - payload_valid, tx_valid, rx_overrun, frame_error = 0.
  - response_ready = 1.
  - RX FSM = R_CMD; TX FSM = T_IDLE.
- Frame format: [cmd byte][length byte][length × BYTES_PER_WORD data bytes, each word big-endian].
- RX FSM:
  - R_CMD: on rx_valid, register cmd and go to R_LEN.
  - R_LEN: on rx_valid, register payload_length, load the header beat (payload_data=0, payload_valid=1) and go to R_DATA. If length==0, go to R_CMD instead.
  - R_DATA: shift bytes into the assembly register (byte counter 0..BYTES_PER_WORD-1). On the last byte, load the word into the output register and set payload_valid the next cycle. Decrement the remaining-word counter; at 0 go to R_CMD.
- Output beat register: one entry.
  - payload_valid stays high and payload_data stays stable until valid&&ready.
  - Word completes while payload_valid=1 and no accept that cycle: word dropped, rx_overrun pulses, counters still advance.
  - Accept and completion in the same cycle: new word loaded, payload_valid stays 1, no overrun.
- cmd and payload_length hold their values until the next frame's cmd byte is registered.
- spi_frame_end:
  - In R_LEN, or in R_DATA with words or bytes outstanding: pulse frame_error, return to R_CMD, clear the byte counter.
  - A pending beat is not retracted.
  - In R_CMD: no effect.
  - spi_frame_end and rx_valid in the same cycle: the byte is processed first, then the abort applies.
- TX FSM:
  - T_IDLE: response_ready=1. On response_valid, capture the word and go to T_SEND (response_ready=0 from the next cycle).
  - T_SEND: tx_valid=1, tx_byte = byte[index], MSB first. Index advances on tx_ready. After the last byte is accepted, return to T_IDLE.
  - Latency: capture at cycle N → tx_valid with MSB at N+1.
  - Back-to-back response words: one T_IDLE cycle between words.
- RX and TX paths are independent; spi_frame_end does not affect TX.
- Width rule: length counter is 8-bit, so up to 255 words per frame.

Optional Feature:
- Macro: EKF_BRIDGE_TX_CSUM_EN.
- Defined: after the last data byte of each response word, TX sends one extra byte = XOR of the word's BYTES_PER_WORD bytes, then returns to T_IDLE.
- Undefined: no checksum byte; exactly BYTES_PER_WORD bytes per word.

Test Plan:
- Bytes 01,02,DE,AD,BE,EF,00,00,00,05 with payload_ready=1 → header beat (cmd=01, length=02, data=0), then data 0xDEADBEEF, then 0x00000005; FSM returns to R_CMD.
- Bytes 10,00 → cmd=0x10, length=0, single header beat; no data beats.
- payload_ready=0 throughout a 2-word frame → header beat held; both data words dropped; rx_overrun pulses twice.
- Bytes 02,03,11,22 then spi_frame_end → frame_error pulses once; next byte 20 registers as cmd=0x20.
- response_data=0x12345678 with tx_ready toggling 1,0,1,1,1 → tx_byte sequence 12,34,56,78; response_ready=0 until the last byte is accepted.
- With EKF_BRIDGE_TX_CSUM_EN, response 0x12345678 → bytes 12,34,56,78,08.
